// File: rtl/dff_timing_monitor.sv
// Oversampling timing checker for a posedge DFF with active-low preset/clear.
// Reports setup/hold/period/width/recovery violations measured in sample ticks.
module dff_timing_monitor #(
    parameter int CW    = 8,
    parameter int T_SU  = 10,
    parameter int T_HD  = 1,
    parameter int T_PW  = 25,
    parameter int T_WPC = 10,
    parameter int T_REC = 5,
    parameter int NW    = 16
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          dut_clk,
    input  logic          dut_data,
    input  logic          dut_preset,
    input  logic          dut_clear,
    input  logic          clr_flags,
    output logic          notifier,
    output logic          viol_valid,
    output logic [2:0]    viol_code,
    output logic [5:0]    viol_flags,
    output logic [NW-1:0] viol_count
);

    typedef enum logic [2:0] {
        V_NONE  = 3'd0,
        V_SU    = 3'd1,
        V_HD    = 3'd2,
        V_PER   = 3'd3,
        V_WID_P = 3'd4,
        V_WID_C = 3'd5,
        V_REC   = 3'd6
    } viol_code_e;

    localparam logic [CW-1:0] AGE_MAX = '1;

    logic          primed_q;
    logic          dut_clk_q, dut_data_q, dut_preset_q, dut_clear_q;
    logic [CW-1:0] data_age_q, clk_age_q, pre_age_q, clr_age_q, rec_age_q;
    logic [CW-1:0] data_age_d, clk_age_d, pre_age_d, clr_age_d, rec_age_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          armed_q, armed_d;
    logic          notifier_q, notifier_d;
    logic          valid_q, valid_d;
    viol_code_e    code_q, code_d;
    logic [5:0]    flags_q, flags_d;
    logic [NW-1:0] count_q, count_d;

    logic          clk_rise, data_chg, pre_fall, pre_rise, clr_fall, clr_rise;
    logic          en_rise, viol_any;
    logic [5:0]    viol;

    function automatic logic [CW-1:0] age_next(input logic ev, input logic [CW-1:0] age);
        if (ev)
            return '0;
        if (age == AGE_MAX)
            return age;
        return age + CW'(1);
    endfunction

    // Edges are suppressed on the first edge after reset while history is loaded.
    always_comb begin
        clk_rise = primed_q & dut_clk & ~dut_clk_q;
        data_chg = primed_q & (dut_data ^ dut_data_q);
        pre_fall = primed_q & ~dut_preset & dut_preset_q;
        pre_rise = primed_q & dut_preset & ~dut_preset_q;
        clr_fall = primed_q & ~dut_clear & dut_clear_q;
        clr_rise = primed_q & dut_clear & ~dut_clear_q;
        en_rise  = clk_rise & dut_preset & dut_clear;

        viol    = '0;
        viol[0] = en_rise & (data_chg | (int'(data_age_q) < T_SU - 1));
        viol[1] = data_chg & (hold_cnt_q != '0);
        viol[2] = clk_rise & armed_q & (int'(clk_age_q) < T_PW - 1);
        viol[3] = pre_rise & (int'(pre_age_q) < T_WPC - 1);
        viol[4] = clr_rise & (int'(clr_age_q) < T_WPC - 1);
        viol[5] = clk_rise & (int'(rec_age_q) < T_REC - 1);
        viol_any = |viol;

        data_age_d = age_next(data_chg, data_age_q);
        clk_age_d  = age_next(clk_rise, clk_age_q);
        pre_age_d  = age_next(pre_fall, pre_age_q);
        clr_age_d  = age_next(clr_fall, clr_age_q);
        rec_age_d  = age_next(pre_rise | clr_rise, rec_age_q);

        hold_cnt_d = hold_cnt_q;
        if (en_rise)
            hold_cnt_d = CW'(T_HD);
        else if (hold_cnt_q != '0)
            hold_cnt_d = hold_cnt_q - CW'(1);

        armed_d = armed_q | clk_rise;

        code_d = V_NONE;
        if (viol[5]) code_d = V_REC;
        if (viol[4]) code_d = V_WID_C;
        if (viol[3]) code_d = V_WID_P;
        if (viol[2]) code_d = V_PER;
        if (viol[1]) code_d = V_HD;
        if (viol[0]) code_d = V_SU;

        valid_d    = viol_any;
        notifier_d = notifier_q ^ viol_any;

        // A same-cycle clear keeps only the violation being reported now.
        if (clr_flags) begin
            flags_d = viol;
            count_d = viol_any ? NW'(1) : '0;
        end else begin
            flags_d = flags_q | viol;
            count_d = count_q;
            if (viol_any && count_q != '1)
                count_d = count_q + NW'(1);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            primed_q     <= 1'b0;
            dut_clk_q    <= 1'b0;
            dut_data_q   <= 1'b0;
            dut_preset_q <= 1'b0;
            dut_clear_q  <= 1'b0;
            data_age_q   <= AGE_MAX;
            clk_age_q    <= AGE_MAX;
            pre_age_q    <= AGE_MAX;
            clr_age_q    <= AGE_MAX;
            rec_age_q    <= AGE_MAX;
            hold_cnt_q   <= '0;
            armed_q      <= 1'b0;
            notifier_q   <= 1'b0;
            valid_q      <= 1'b0;
            code_q       <= V_NONE;
            flags_q      <= '0;
            count_q      <= '0;
        end else begin
            primed_q     <= 1'b1;
            dut_clk_q    <= dut_clk;
            dut_data_q   <= dut_data;
            dut_preset_q <= dut_preset;
            dut_clear_q  <= dut_clear;
            data_age_q   <= data_age_d;
            clk_age_q    <= clk_age_d;
            pre_age_q    <= pre_age_d;
            clr_age_q    <= clr_age_d;
            rec_age_q    <= rec_age_d;
            hold_cnt_q   <= hold_cnt_d;
            armed_q      <= armed_d;
            notifier_q   <= notifier_d;
            valid_q      <= valid_d;
            code_q       <= code_d;
            flags_q      <= flags_d;
            count_q      <= count_d;
        end
    end

    assign notifier   = notifier_q;
    assign viol_valid = valid_q;
    assign viol_code  = code_q;
    assign viol_flags = flags_q;
    assign viol_count = count_q;

endmodule

// File: tb/tb_dff_timing_monitor.sv
// Scoreboard bench for dff_timing_monitor: an event-time reference model
// queues the expected registered outputs, a monitor compares them each cycle.
module tb_dff_timing_monitor;

    localparam int CW    = 5;
    localparam int T_SU  = 10;
    localparam int T_HD  = 1;
    localparam int T_PW  = 25;
    localparam int T_WPC = 10;
    localparam int T_REC = 5;
    localparam int NW    = 4;
    localparam int AMAX  = (1 << CW) - 1;
    localparam int CMAX  = (1 << NW) - 1;
    localparam int NEVER = -100000;

    logic          clock = 1'b0;
    logic          clear, dut_clk, dut_data, dut_preset, dut_clear, clr_flags;
    logic          notifier, viol_valid;
    logic [2:0]    viol_code;
    logic [5:0]    viol_flags;
    logic [NW-1:0] viol_count;

    dff_timing_monitor #(
        .CW(CW), .T_SU(T_SU), .T_HD(T_HD), .T_PW(T_PW),
        .T_WPC(T_WPC), .T_REC(T_REC), .NW(NW)
    ) dut (
        .clock(clock), .clear(clear), .dut_clk(dut_clk), .dut_data(dut_data),
        .dut_preset(dut_preset), .dut_clear(dut_clear), .clr_flags(clr_flags),
        .notifier(notifier), .viol_valid(viol_valid), .viol_code(viol_code),
        .viol_flags(viol_flags), .viol_count(viol_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       n;
        bit       v;
        bit [2:0] code;
        bit [5:0] flags;
        int       count;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // stimulus state
    bit s_rst = 0, s_clk = 0, s_data = 0, s_pre = 1, s_clr = 1, s_cf = 0;

    // reference model: absolute event times instead of counters
    int k = 0;
    bit m_primed = 0, m_armed = 0, m_not = 0;
    bit p_clk, p_data, p_pre, p_clr;
    int t_data = NEVER, t_clk = NEVER, t_pf = NEVER, t_cf = NEVER, t_rec = NEVER, t_en = NEVER;
    bit [5:0] m_flags = 0;
    int m_count = 0;

    function automatic int age(input int t);
        int a;
        a = k - t - 1;
        return (a > AMAX) ? AMAX : a;
    endfunction

    task automatic model_step();
        exp_t e;
        bit [5:0] vb;
        bit rise, chg, pf, pr, cf, cr, en;
        e.n = 0; e.v = 0; e.code = 0; e.flags = 0; e.count = 0;
        if (!s_rst) begin
            m_primed = 0; m_armed = 0; m_not = 0; m_flags = 0; m_count = 0;
            t_data = NEVER; t_clk = NEVER; t_pf = NEVER; t_cf = NEVER;
            t_rec = NEVER; t_en = NEVER;
        end else begin
            rise = m_primed && s_clk && !p_clk;
            chg  = m_primed && (s_data != p_data);
            pf   = m_primed && !s_pre && p_pre;
            pr   = m_primed && s_pre && !p_pre;
            cf   = m_primed && !s_clr && p_clr;
            cr   = m_primed && s_clr && !p_clr;
            en   = s_pre && s_clr;
            vb = 0;
            vb[0] = rise && en && (chg || age(t_data) < T_SU - 1);
            vb[1] = chg && (k - t_en >= 1) && (k - t_en <= T_HD);
            vb[2] = rise && m_armed && (age(t_clk) < T_PW - 1);
            vb[3] = pr && (age(t_pf) < T_WPC - 1);
            vb[4] = cr && (age(t_cf) < T_WPC - 1);
            vb[5] = rise && (age(t_rec) < T_REC - 1);
            if (chg) t_data = k;
            if (rise) begin t_clk = k; m_armed = 1; end
            if (rise && en) t_en = k;
            if (pf) t_pf = k;
            if (cf) t_cf = k;
            if (pr || cr) t_rec = k;
            if (s_cf) begin
                m_flags = vb;
                m_count = (vb != 0) ? 1 : 0;
            end else begin
                m_flags = m_flags | vb;
                if (vb != 0 && m_count < CMAX) m_count = m_count + 1;
            end
            if (vb != 0) m_not = !m_not;
            e.v = (vb != 0);
            for (int i = 5; i >= 0; i--)
                if (vb[i]) e.code = 3'(i + 1);
            e.n = m_not; e.flags = m_flags; e.count = m_count;
            m_primed = 1;
            p_clk = s_clk; p_data = s_data; p_pre = s_pre; p_clr = s_clr;
        end
        sb.push_back(e);
        k++;
    endtask

    task automatic tick();
        @(negedge clock);
        clear = s_rst; dut_clk = s_clk; dut_data = s_data;
        dut_preset = s_pre; dut_clear = s_clr; clr_flags = s_cf;
        model_step();
        s_cf = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // directed checks sample right after the edge that consumed the last tick
    task automatic after_edge();
        @(posedge clock);
        #3;
    endtask

    // monitor: every clock the DUT presents a registered result
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (notifier !== e.n || viol_valid !== e.v || viol_code !== e.code ||
                    viol_flags !== e.flags || int'(viol_count) != e.count) begin
                    errors++;
                    if (errors < 30)
                        $display("FAIL scoreboard t=%0t got n=%0b v=%0b code=%0d flags=%b count=%0d expected n=%0b v=%0b code=%0d flags=%b count=%0d",
                                 $time, notifier, viol_valid, viol_code, viol_flags, viol_count,
                                 e.n, e.v, e.code, e.flags, e.count);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clear = 0; dut_clk = 0; dut_data = 0; dut_preset = 1; dut_clear = 1; clr_flags = 0;

        // reset state
        idle(3);
        after_edge();
        chk("reset_valid", int'(viol_valid), 0);
        chk("reset_count", int'(viol_count), 0);
        chk("reset_notifier", int'(notifier), 0);
        s_rst = 1;
        idle(40);

        // setup: data change, enabled rise five ticks later
        s_data = 1; tick();
        idle(4);
        s_clk = 1; tick();
        after_edge();
        chk("su_code", int'(viol_code), 1);
        chk("su_notifier", int'(notifier), 1);

        // hold: change one tick after rise violates, two ticks after does not
        s_clk = 0; idle(30);
        s_clk = 1; tick();
        s_data = 0; tick();
        after_edge();
        chk("hd_code", int'(viol_code), 2);
        s_data = 1; tick();
        after_edge();
        chk("hd_outside_window", int'(viol_valid), 0);

        // period: 20 ticks violates, 25 ticks does not
        s_clk = 0; idle(30);
        s_clk = 1; tick();
        s_clk = 0; idle(19);
        s_clk = 1; tick();
        after_edge();
        chk("per_code", int'(viol_code), 3);
        s_clk = 0; idle(24);
        s_clk = 1; tick();
        after_edge();
        chk("per_ok", int'(viol_valid), 0);

        // preset width 5, then recovery 3 ticks after clear rise
        s_clk = 0; idle(30);
        s_pre = 0; tick();
        idle(4);
        s_pre = 1; tick();
        after_edge();
        chk("wid_p_code", int'(viol_code), 4);
        idle(20);
        s_clr = 0; tick();
        idle(15);
        s_clr = 1; tick();
        idle(2);
        s_clk = 1; tick();
        after_edge();
        chk("rec_code", int'(viol_code), 6);

        // SU+PER+REC in one cycle together with clr_flags
        s_clk = 0; idle(30);
        s_clk = 1; tick();
        s_clk = 0; idle(5);
        s_clr = 0; tick();
        idle(11);
        s_clr = 1; tick();
        s_data = !s_data; tick();
        s_clk = 1; s_cf = 1; tick();
        after_edge();
        chk("multi_flags", int'(viol_flags), 6'b100101);
        chk("multi_code", int'(viol_code), 1);
        chk("multi_count", int'(viol_count), 1);

        // drive the counter into saturation
        s_clk = 0; tick();
        for (int i = 0; i < 20; i++) begin
            s_data = !s_data; tick();
            s_clk = 1; tick();
            s_clk = 0; tick();
        end
        after_edge();
        chk("count_saturated", int'(viol_count), CMAX);

        // reset inside an open hold window
        idle(30);
        s_clk = 1; tick();
        s_rst = 0; s_data = !s_data; tick();
        after_edge();
        chk("rst_mid_valid", int'(viol_valid), 0);
        chk("rst_mid_count", int'(viol_count), 0);
        chk("rst_mid_flags", int'(viol_flags), 0);
        s_rst = 1; idle(5);
        after_edge();
        chk("rst_mid_after", int'(viol_valid), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) s_clk = !s_clk;
            if ($urandom_range(0, 9) == 0) s_data = !s_data;
            if ($urandom_range(0, 39) == 0) s_pre = !s_pre;
            if ($urandom_range(0, 39) == 0) s_clr = !s_clr;
            s_cf  = ($urandom_range(0, 49) == 0);
            s_rst = ($urandom_range(0, 399) != 0);
            tick();
        end
        s_rst = 1;
        idle(3);

        for (int i = 0; i < 10 && sb.size() != 0; i++)
            @(posedge clock);
        #3;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
